// File: rtl/tt_capture_if.sv
// Nibble stream carrying a captured truth table, MSB nibble first.
//   nib_valid : stream valid (from engine)
//   nib_ready : downstream ready (to engine)
//   nib_data  : current nibble
//   nib_last  : high with the final nibble
interface tt_capture_if;
  logic       nib_valid;
  logic       nib_ready;
  logic [3:0] nib_data;
  logic       nib_last;

  modport master (output nib_valid, output nib_data, output nib_last, input nib_ready);
  modport slave  (input nib_valid, input nib_data, input nib_last, output nib_ready);
endinterface

// File: rtl/tt_capture_engine.sv
// Sequential truth-table extractor. Sweeps every input vector of an external
// combinational function, samples its output after SETTLE cycles per vector,
// then streams the assembled table out as MSB-first hex nibbles.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a capture (honoured only when idle)
//   x_out    : registered input vector to the function under test
//   f_in     : function output
//   busy     : capture/stream in progress
//   done     : one-cycle pulse after the last nibble transfers
//   tt_out   : captured table, bit i = f(x = i)
//   nib      : nibble stream (master side)
module tt_capture_engine #(
  parameter int NUM_IN = 7,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [NUM_IN-1:0]        x_out,
  input  logic                     f_in,
  output logic                     busy,
  output logic                     done,
  output logic [(1<<NUM_IN)-1:0]   tt_out,
  tt_capture_if.master             nib
);

  localparam int TT_W  = 1 << NUM_IN;
  localparam int NIB_N = TT_W / 4;
  localparam int NI_W  = (NUM_IN > 2) ? NUM_IN - 2 : 1;

  localparam logic [NUM_IN-1:0] VC_LAST = '1;
  localparam logic [3:0]        SC_LAST = 4'(SETTLE - 1);
  localparam logic [NI_W-1:0]   NI_LAST = NI_W'(NIB_N - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, STREAM, FIN} state_t;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] vc;
  logic [3:0]        sc;
  logic [NI_W-1:0]   ni;

  logic              sample_now;
  int                shamt;
  logic [TT_W-1:0]   tt_sh;

  // The vector counter is itself the registered drive to the function.
  assign x_out      = vc;
  assign sample_now = (state_q == DRIVE) && (sc == SC_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (sample_now && (vc == VC_LAST)) state_d = STREAM;
      STREAM:  if (nib.nib_ready && (ni == NI_LAST)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: sweep counters, table capture, nibble index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc     <= '0;
      sc     <= '0;
      ni     <= '0;
      tt_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            vc     <= '0;
            sc     <= '0;
            ni     <= '0;
            tt_out <= '0;
          end
        end
        DRIVE: begin
          if (sample_now) begin
            tt_out[vc] <= f_in;
            sc         <= '0;
            // Wrapping to 0 after the last vector also returns x_out to 0.
            vc         <= (vc == VC_LAST) ? '0 : vc + NUM_IN'(1);
          end else begin
            sc <= sc + 4'd1;
          end
        end
        STREAM: begin
          if (nib.nib_ready) ni <= (ni == NI_LAST) ? '0 : ni + NI_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state, so they hold steady while
  // the stream is stalled.
  always_comb begin
    shamt         = 4 * (NIB_N - 1 - int'(ni));
    tt_sh         = tt_out >> shamt;
    busy          = (state_q == DRIVE) || (state_q == STREAM);
    done          = (state_q == FIN);
    nib.nib_valid = (state_q == STREAM);
    nib.nib_last  = (state_q == STREAM) && (ni == NI_LAST);
    nib.nib_data  = (state_q == STREAM) ? tt_sh[3:0] : 4'd0;
  end

endmodule
